main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multi-cycle main control unit for the 64-bit RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the `aluOp` code that `alu_control` consumes, using 00 for address/PC add, 01 for branch compare and 10 for R-type funct decode, together with all datapath strobes. It supports `ld`, `sd`, `beq` and R-type (`add`, `sub`, `and`, `or`), with a memory ready handshake and a retired-instruction counter.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 7: `instr[6:0]` from the instruction register. It must be stable from DECODE until the instruction completes.
- `memReady` input 1: memory completes the current read or write this cycle.
- `aluOp` output 2: to `alu_control`.
- `aluSrcA` output 2: 00 = PC, 01 = register A.
- `aluSrcB` output 2: 00 = register B, 01 = constant 4, 10 = immediate.
- `pcWrite`, `pcWriteCond`, `pcSource`, `iorD`, `memRead`, `memWrite`, `irWrite`, `memToReg`, `regWrite` output 1 each: datapath strobes.
- `illegalInstr` output 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` output 4: current state encoding, for debug.
- `retired` output 32: count of completed legal instructions.

## Operation
States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8. Encodings 9–15 are unreachable and recover to FETCH on the next edge.

Outputs are Moore decodes of `state`, except the `memReady`-qualified strobes, which are combinational. Any signal not listed for a state is 0.

- **FETCH:** `memRead`=1, `aluSrcA`=00, `aluSrcB`=01, `aluOp`=00. `irWrite` and `pcWrite` equal `memReady`. Stays in FETCH until `memReady`, then goes to DECODE.
- **DECODE:** `aluSrcA`=00, `aluSrcB`=10, `aluOp`=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 (`ld`) or 0100011 (`sd`) → MEM_ADDR
  - 0110011 (R-type) → EXECUTE
  - 1100011 (`beq`) → BRANCH
  - any other opcode → FETCH, with `illegalInstr`=1 for this cycle
- **MEM_ADDR:** `aluSrcA`=01, `aluSrcB`=10, `aluOp`=00. Goes to MEM_READ if `ld`, MEM_WRITE if `sd`.
- **MEM_READ:** `memRead`=1, `iorD`=1. Waits for `memReady`, then goes to MEM_WB.
- **MEM_WB:** `regWrite`=1, `memToReg`=1. Goes to FETCH.
- **MEM_WRITE:** `memWrite`=1, `iorD`=1. Waits for `memReady`, then goes to FETCH.
- **EXECUTE:** `aluSrcA`=01, `aluSrcB`=00, `aluOp`=10. Goes to ALU_WB.
- **ALU_WB:** `regWrite`=1, `memToReg`=0. Goes to FETCH.
- **BRANCH:** `aluSrcA`=01, `aluSrcB`=00, `aluOp`=01, `pcWriteCond`=1, `pcSource`=1. Goes to FETCH.

`retired` increments by 1, modulo 2^32, on each transition into FETCH from MEM_WB, MEM_WRITE (with `memReady`), ALU_WB or BRANCH. It does not increment on an illegal-opcode return. From 0xFFFFFFFF it wraps to 0.

## Timing
- **Reset:** while `rst_n`=0, `state`=FETCH, `retired`=0, `aluOp`=`aluSrcA`=`aluSrcB`=00, and every strobe including `memRead` and `illegalInstr` is forced to 0. Strobes release at the first clock after deassertion.
- **Reset mid-instruction:** the FSM returns to FETCH immediately and no further writes are issued. A partially executed instruction is not counted.
- **Cycles per instruction** with `memReady` held at 1: `ld` 5, `sd` 4, R-type 4, `beq` 3, illegal 2. Each cycle `memReady` is low inside FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Outputs hold steady during the wait.
- `memReady` is ignored in all states other than FETCH, MEM_READ and MEM_WRITE.
- `irWrite` and `pcWrite` assert only in the FETCH cycle where `memReady`=1. They never assert during a FETCH wait.
- Opcode is sampled only in DECODE and MEM_ADDR.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `memReady`=1 → `state`=0, all strobes 0, `retired`=0. Release `rst_n` → `memRead`=1 and `pcWrite`=1 in the first FETCH cycle.
- **ld, no waits:** opcode 0000011, `memReady`=1 → `state` sequence 0,1,2,3,4,0. `aluOp` 00 in states 0–2. `regWrite`=`memToReg`=1 in state 4. `retired`=1.
- **sd, then beq:** opcode 0100011 → `state` sequence 0,1,2,5,0 with `memWrite`=1 in state 5. Then opcode 1100011 → `state` sequence 0,1,8,0 with `aluOp`=01 and `pcWriteCond`=1 in state 8. `retired`=2.
- **R-type:** opcode 0110011 → EXECUTE has `aluOp`=10, `aluSrcB`=00. ALU_WB has `regWrite`=1, `memToReg`=0.
- **Wait states:** `ld` with `memReady` low for 2 cycles in both FETCH and MEM_READ → 9 cycles total. `irWrite` pulses exactly once.
- **Illegal and reset/wrap corners:**
  - opcode 1111111 → `illegalInstr` pulses 1 cycle, back to FETCH, `retired` unchanged.
  - `rst_n` dropped in MEM_READ → FETCH immediately, no `regWrite`.
  - `retired` forced to 0xFFFFFFFF, then one R-type completes → `retired` reads 0.

Source files
------------

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle main control FSM for the 64-bit RISC-V datapath
// Sequences ld/sd/beq/R-type through fetch..writeback and counts retired instructions.
module main_control_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        memReady,
    output logic [1:0]  aluOp,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        pcSource,
    output logic        iorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        memToReg,
    output logic        regWrite,
    output logic        illegalInstr,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_SD     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_q;
    state_t      state_d;
    logic        run_q;
    logic        retire;
    logic [31:0] retired_q;

    // run_q holds every strobe low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        aluOp        = 2'b00;
        aluSrcA      = 2'b00;
        aluSrcB      = 2'b00;
        pcWrite      = 1'b0;
        pcWriteCond  = 1'b0;
        pcSource     = 1'b0;
        iorD         = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        irWrite      = 1'b0;
        memToReg     = 1'b0;
        regWrite     = 1'b0;
        illegalInstr = 1'b0;

        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = 2'b01;
                    irWrite = memReady;
                    pcWrite = memReady;
                    if (memReady) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // PC + imm is parked in ALUOut for a possible branch
                    aluSrcB = 2'b10;
                    case (opcode)
                        OP_LD, OP_SD: state_d = S_MEM_ADDR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BRANCH:    state_d = S_BRANCH;
                        default: begin
                            state_d      = S_FETCH;
                            illegalInstr = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    aluSrcA = 2'b01;
                    aluSrcB = 2'b10;
                    state_d = (opcode == OP_SD) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                    if (memReady) begin
                        state_d = S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                    state_d  = S_FETCH;
                    retire   = 1'b1;
                end
                S_MEM_WRITE: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                    if (memReady) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    aluSrcA = 2'b01;
                    aluOp   = 2'b10;
                    state_d = S_ALU_WB;
                end
                S_ALU_WB: begin
                    regWrite = 1'b1;
                    state_d  = S_FETCH;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA     = 2'b01;
                    aluOp       = 2'b01;
                    pcWriteCond = 1'b1;
                    pcSource    = 1'b1;
                    state_d     = S_FETCH;
                    retire      = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - scoreboard bench for main_control_fsm
module tb_main_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        memReady = 1'b0;
    logic [1:0]  aluOp, aluSrcA, aluSrcB;
    logic        pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite;
    logic        irWrite, memToReg, regWrite, illegalInstr;
    logic [3:0]  state;
    logic [31:0] retired;

    main_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource),
        .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regWrite(regWrite), .illegalInstr(illegalInstr),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [1:0]  aop;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [9:0]  stb;
        logic [31:0] ret;
    } obs_t;

    // stb bits: pcWrite pcWriteCond pcSource iorD memRead memWrite irWrite memToReg regWrite illegalInstr
    localparam int B_PCW = 9, B_PCC = 8, B_PCS = 7, B_IORD = 6, B_MRD = 5;
    localparam int B_MWR = 4, B_IRW = 3, B_M2R = 2, B_RW = 1, B_ILL = 0;

    obs_t        exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model_ret = 32'd0;
    logic [6:0]  cur_op = 7'd0;
    obs_t        mon_e, mon_a;
    string       mon_n;

    function automatic int op_class(input logic [6:0] op);
        if (op == 7'b0000011) return 0;
        if (op == 7'b0100011) return 1;
        if (op == 7'b0110011) return 2;
        if (op == 7'b1100011) return 3;
        return 4;
    endfunction

    function automatic obs_t expect_of(input logic [3:0] st, input logic mr, input logic live);
        obs_t e;
        e     = '0;
        e.ret = model_ret;
        if (!live) return e;
        e.st = st;
        case (st)
            4'd0: begin e.sb = 2'b01; e.stb[B_MRD] = 1'b1; e.stb[B_IRW] = mr; e.stb[B_PCW] = mr; end
            4'd1: begin e.sb = 2'b10; e.stb[B_ILL] = (op_class(cur_op) == 4); end
            4'd2: begin e.sa = 2'b01; e.sb = 2'b10; end
            4'd3: begin e.stb[B_MRD] = 1'b1; e.stb[B_IORD] = 1'b1; end
            4'd4: begin e.stb[B_RW] = 1'b1; e.stb[B_M2R] = 1'b1; end
            4'd5: begin e.stb[B_MWR] = 1'b1; e.stb[B_IORD] = 1'b1; end
            4'd6: begin e.sa = 2'b01; e.aop = 2'b10; end
            4'd7: begin e.stb[B_RW] = 1'b1; end
            4'd8: begin e.sa = 2'b01; e.aop = 2'b01; e.stb[B_PCC] = 1'b1; e.stb[B_PCS] = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_a = {state, aluOp, aluSrcA, aluSrcB,
                     {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite,
                      irWrite, memToReg, regWrite, illegalInstr}, retired};
            n_tests++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d aluOp=%b srcA=%b srcB=%b strobes=%b retired=%h, expected st=%0d aluOp=%b srcA=%b srcB=%b strobes=%b retired=%h",
                         mon_n, mon_a.st, mon_a.aop, mon_a.sa, mon_a.sb, mon_a.stb, mon_a.ret,
                         mon_e.st, mon_e.aop, mon_e.sa, mon_e.sb, mon_e.stb, mon_e.ret);
            end
        end
    end

    task automatic step(input logic [3:0] st, input logic mr, input string nm);
        @(posedge clk);
        #1;
        memReady = mr;
        exp_q.push_back(expect_of(st, mr, 1'b1));
        name_q.push_back(nm);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n     = 1'b0;
            memReady  = 1'b1;
            model_ret = 32'd0;
            exp_q.push_back(expect_of(4'd0, 1'b1, 1'b0));
            name_q.push_back("reset");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(expect_of(4'd0, 1'b1, 1'b0));
        name_q.push_back("reset_release");
    endtask

    function automatic logic rnd_bit();
        return $urandom_range(0, 1) != 0;
    endfunction

    task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
        int c;
        c = op_class(op);
        @(posedge clk);
        #1;
        opcode = op;
        cur_op = op;
        memReady = (wf == 0);
        exp_q.push_back(expect_of(4'd0, memReady, 1'b1));
        name_q.push_back("fetch");
        for (int i = 0; i < wf; i++) step(4'd0, (i == wf - 1), "fetch");
        step(4'd1, rnd_bit(), "decode");
        case (c)
            0: begin
                step(4'd2, rnd_bit(), "ld_addr");
                for (int i = 0; i < wm; i++) step(4'd3, 1'b0, "ld_wait");
                step(4'd3, 1'b1, "ld_read");
                step(4'd4, rnd_bit(), "ld_wb");
            end
            1: begin
                step(4'd2, rnd_bit(), "sd_addr");
                for (int i = 0; i < wm; i++) step(4'd5, 1'b0, "sd_wait");
                step(4'd5, 1'b1, "sd_write");
            end
            2: begin
                step(4'd6, rnd_bit(), "r_exec");
                step(4'd7, rnd_bit(), "r_wb");
            end
            3: step(4'd8, rnd_bit(), "beq");
            default: ;
        endcase
        if (c != 4) model_ret = model_ret + 32'd1;
    endtask

    initial begin
        logic [6:0] rop;
        do_reset(3);

        run_instr(7'b0000011, 0, 0);
        run_instr(7'b0100011, 0, 0);
        run_instr(7'b1100011, 0, 0);
        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 2, 2);
        run_instr(7'b1111111, 0, 0);
        run_instr(7'b0100011, 1, 3);

        // ld cut short by reset while waiting in MEM_READ
        @(posedge clk);
        #1;
        opcode = 7'b0000011;
        cur_op = opcode;
        memReady = 1'b1;
        exp_q.push_back(expect_of(4'd0, 1'b1, 1'b1));
        name_q.push_back("fetch");
        step(4'd1, 1'b1, "decode");
        step(4'd2, 1'b1, "ld_addr");
        step(4'd3, 1'b0, "ld_wait");
        do_reset(2);
        step(4'd0, 1'b0, "post_reset_fetch");

        // counter wrap
        @(posedge clk);
        #1;
        force dut.retired_q = 32'hFFFF_FFFF;
        memReady  = 1'b0;
        model_ret = 32'hFFFF_FFFF;
        exp_q.push_back(expect_of(4'd0, 1'b0, 1'b1));
        name_q.push_back("wrap_preload");
        @(posedge clk);
        #1;
        release dut.retired_q;
        exp_q.push_back(expect_of(4'd0, 1'b0, 1'b1));
        name_q.push_back("wrap_hold");
        run_instr(7'b0110011, 0, 0);
        step(4'd0, 1'b0, "wrap_result");

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: rop = 7'b0000011;
                1: rop = 7'b0100011;
                2: rop = 7'b0110011;
                3: rop = 7'b1100011;
                4: rop = 7'b1111111;
                default: rop = 7'($urandom_range(0, 127));
            endcase
            run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        step(4'd0, 1'b0, "final_idle");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
